// File: rtl/seg_pkg.sv
// Shared types and segment codes for the multiplexed 7-segment display driver.
// Segment bytes are active-low: bit7 = dp (kept off), bits6..0 = g..a.
package seg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_DASH  = 8'hBF;
    localparam logic [7:0] SEG_DIGIT [10] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
        8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
    };

    // Non-BCD nibbles cannot occur after a clean conversion; show them blank.
    function automatic logic [7:0] seg_encode(input logic [3:0] nib);
        if (nib > 4'd9) begin
            return SEG_BLANK;
        end
        return SEG_DIGIT[nib];
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one shift-add-3 step per clock, DATA_W steps.
// Carries one spare nibble plus a sticky bit so the caller can detect overflow.
module bin2bcd_seq #(
    parameter int DATA_W = 8,
    parameter int DIGITS = 3
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      start_i,
    input  logic [DATA_W-1:0]         bin_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic [(DIGITS+1)*4-1:0]   bcd_o,
    output logic                      sticky_o
);

    localparam int BCD_W = (DIGITS + 1) * 4;
    localparam int CNT_W = $clog2(DATA_W + 1);

    logic [DATA_W-1:0] bin_q;
    logic [BCD_W-1:0]  bcd_q;
    logic [BCD_W-1:0]  adj_d;
    logic              sticky_q;
    logic              busy_q;
    logic [CNT_W-1:0]  cnt_q;

    always_comb begin
        adj_d = bcd_q;
        for (int i = 0; i < DIGITS + 1; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                adj_d[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            bin_q    <= '0;
            bcd_q    <= '0;
            sticky_q <= 1'b0;
            busy_q   <= 1'b0;
            cnt_q    <= '0;
        end else if (start_i) begin
            bin_q    <= bin_i;
            bcd_q    <= '0;
            sticky_q <= 1'b0;
            busy_q   <= 1'b1;
            cnt_q    <= CNT_W'(DATA_W);
        end else if (busy_q) begin
            bin_q    <= bin_q << 1;
            bcd_q    <= {adj_d[BCD_W-2:0], bin_q[DATA_W-1]};
            sticky_q <= sticky_q | adj_d[BCD_W-1];
            cnt_q    <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                busy_q <= 1'b0;
            end
        end
    end

    // done_o marks the cycle whose clock edge performs the final shift.
    assign busy_o   = busy_q;
    assign done_o   = busy_q & (cnt_q == CNT_W'(1));
    assign bcd_o    = bcd_q;
    assign sticky_o = sticky_q;

endmodule

// File: rtl/seg_display_driver.sv
// Loads a binary value, converts it to BCD in the background and scans the
// committed digits onto a multiplexed common-anode 7-segment panel.
module seg_display_driver
    import seg_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int DIGITS   = 3,
    parameter int SCAN_DIV = 100_000,
    parameter int BLANK_LZ = 1
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic [DATA_W-1:0] Valor,
    input  logic              Cargar,
    input  logic              Habilitar,
    output logic              Ocupado,
    output logic              Listo,
    output logic              Desborde,
    output logic [7:0]        Displays,
    output logic [7:0]        Segmentos
);

    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int SCAN_W = $clog2(SCAN_DIV);
    localparam int BCD_W  = (DIGITS + 1) * 4;

    state_t              state_q;
    logic                ocupado_q, listo_q, desborde_q;
    logic [DIGITS*4-1:0] digits_q;

    logic                conv_start, conv_busy, conv_done, conv_sticky;
    logic [BCD_W-1:0]    conv_bcd;

    assign conv_start = (state_q == ST_IDLE) & Cargar & ~conv_busy;

    bin2bcd_seq #(
        .DATA_W (DATA_W),
        .DIGITS (DIGITS)
    ) u_bin2bcd (
        .clk_i    (Clk),
        .rst_ni   (Rst_n),
        .start_i  (conv_start),
        .bin_i    (Valor),
        .busy_o   (conv_busy),
        .done_o   (conv_done),
        .bcd_o    (conv_bcd),
        .sticky_o (conv_sticky)
    );

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q    <= ST_IDLE;
            ocupado_q  <= 1'b0;
            listo_q    <= 1'b0;
            desborde_q <= 1'b0;
            digits_q   <= '0;
        end else begin
            listo_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (conv_start) begin
                        state_q   <= ST_CONV;
                        ocupado_q <= 1'b1;
                    end
                end
                ST_CONV: begin
                    if (conv_done) begin
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    desborde_q <= (conv_bcd[BCD_W-1 -: 4] != 4'd0) | conv_sticky;
                    digits_q   <= conv_bcd[DIGITS*4-1:0];
                    listo_q    <= 1'b1;
                    ocupado_q  <= 1'b0;
                    state_q    <= ST_IDLE;
                end
                default: begin
                    state_q   <= ST_IDLE;
                    ocupado_q <= 1'b0;
                end
            endcase
        end
    end

    logic [SCAN_W-1:0] scan_q;
    logic [IDX_W-1:0]  idx_q;
    logic [7:0]        disp_q, seg_q, disp_d, seg_d;
    logic [3:0]        nib_cur;
    logic              lz_cur, zero_above;

    // zero_above tracks "this digit and all above it are zero" from the top down.
    always_comb begin
        nib_cur    = 4'd0;
        lz_cur     = 1'b0;
        zero_above = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_above = zero_above & (digits_q[4*i +: 4] == 4'd0);
            if (idx_q == IDX_W'(i)) begin
                nib_cur = digits_q[4*i +: 4];
                lz_cur  = zero_above;
            end
        end
        disp_d = 8'hFF;
        seg_d  = SEG_BLANK;
        if (Habilitar) begin
            disp_d = ~(8'd1 << idx_q);
            if (desborde_q) begin
                seg_d = SEG_DASH;
            end else if ((BLANK_LZ != 0) && (idx_q != '0) && lz_cur) begin
                seg_d = SEG_BLANK;
            end else begin
                seg_d = seg_encode(nib_cur);
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            scan_q <= '0;
            idx_q  <= '0;
            disp_q <= 8'hFF;
            seg_q  <= 8'hFF;
        end else begin
            disp_q <= disp_d;
            seg_q  <= seg_d;
            if (scan_q == SCAN_W'(SCAN_DIV - 1)) begin
                scan_q <= '0;
                if (idx_q == IDX_W'(DIGITS - 1)) begin
                    idx_q <= '0;
                end else begin
                    idx_q <= idx_q + IDX_W'(1);
                end
            end else begin
                scan_q <= scan_q + SCAN_W'(1);
            end
        end
    end

    assign Ocupado   = ocupado_q;
    assign Listo     = listo_q;
    assign Desborde  = desborde_q;
    assign Displays  = disp_q;
    assign Segmentos = seg_q;

endmodule

// File: tb/tb_seg_display_driver.sv
// Bench for seg_display_driver: a 3-digit and a 2-digit instance share stimulus and
// are compared every cycle against an arithmetic model of load, commit and scan.
module tb_seg_display_driver;

    localparam int DW = 8;
    localparam int SD = 4;
    localparam logic [7:0] SEG_REF [10] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
    };

    logic          Clk = 1'b0;
    logic          Rst_n = 1'b1;
    logic [DW-1:0] Valor = '0;
    logic          Cargar = 1'b0;
    logic          Habilitar = 1'b1;

    logic       ocup3, listo3, desb3, ocup2, listo2, desb2;
    logic [7:0] disp3, seg3, disp2, seg2;

    seg_display_driver #(.DATA_W(DW), .DIGITS(3), .SCAN_DIV(SD), .BLANK_LZ(1)) dut3 (
        .Clk(Clk), .Rst_n(Rst_n), .Valor(Valor), .Cargar(Cargar), .Habilitar(Habilitar),
        .Ocupado(ocup3), .Listo(listo3), .Desborde(desb3), .Displays(disp3), .Segmentos(seg3)
    );

    seg_display_driver #(.DATA_W(DW), .DIGITS(2), .SCAN_DIV(SD), .BLANK_LZ(1)) dut2 (
        .Clk(Clk), .Rst_n(Rst_n), .Valor(Valor), .Cargar(Cargar), .Habilitar(Habilitar),
        .Ocupado(ocup2), .Listo(listo2), .Desborde(desb2), .Displays(disp2), .Segmentos(seg2)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_fail   = 0;

    int n_edges   = 0;
    bit busy_m    = 1'b0;
    int load_edge = 0;
    int pend_val  = 0;
    int com_val   = 0;
    int prev_val  = 0;
    bit prev_hab  = 1'b1;
    bit listo_m   = 1'b0;

    function automatic int pow10(input int e);
        int r = 1;
        for (int i = 0; i < e; i++) r = r * 10;
        return r;
    endfunction

    function automatic bit ovf(input int val, input int nd);
        return val > pow10(nd) - 1;
    endfunction

    function automatic logic [7:0] ref_seg(input int val, input int nd, input int idx, input bit hab);
        if (!hab) return 8'hFF;
        if (ovf(val, nd)) return 8'hBF;
        if (idx > 0 && val < pow10(idx)) return 8'hFF;
        return SEG_REF[(val / pow10(idx)) % 10];
    endfunction

    function automatic logic [7:0] ref_disp(input int idx, input bit hab);
        if (!hab) return 8'hFF;
        return ~(8'd1 << idx);
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s @edge %0d: got %0h, want %0h", tag, n_edges, got, want);
        end
    endtask

    task automatic check_outputs();
        int i3, i2;
        i3 = ((n_edges - 1) / SD) % 3;
        i2 = ((n_edges - 1) / SD) % 2;
        check_eq("listo3", listo3, listo_m);
        check_eq("listo2", listo2, listo_m);
        check_eq("ocupado3", ocup3, busy_m);
        check_eq("ocupado2", ocup2, busy_m);
        check_eq("desborde3", desb3, ovf(com_val, 3));
        check_eq("desborde2", desb2, ovf(com_val, 2));
        check_eq("displays3", disp3, ref_disp(i3, prev_hab));
        check_eq("displays2", disp2, ref_disp(i2, prev_hab));
        check_eq("segmentos3", seg3, ref_seg(prev_val, 3, i3, prev_hab));
        check_eq("segmentos2", seg2, ref_seg(prev_val, 2, i2, prev_hab));
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_ocupado"}, {ocup3, ocup2}, 2'b00);
        check_eq({tag, "_listo"}, {listo3, listo2}, 2'b00);
        check_eq({tag, "_desborde"}, {desb3, desb2}, 2'b00);
        check_eq({tag, "_displays"}, {disp3, disp2}, 16'hFFFF);
        check_eq({tag, "_segmentos"}, {seg3, seg2}, 16'hFFFF);
    endtask

    // One clock: drive at the falling edge, advance the model at the rising edge,
    // compare at the next falling edge.
    task automatic cycle(input bit ld, input int val, input bit hab);
        Cargar    = ld;
        Valor     = DW'(val);
        Habilitar = hab;
        @(posedge Clk);
        n_edges++;
        prev_val = com_val;
        prev_hab = hab;
        listo_m  = 1'b0;
        if (busy_m && n_edges == load_edge + DW + 1) begin
            com_val = pend_val;
            busy_m  = 1'b0;
            listo_m = 1'b1;
        end else if (!busy_m && ld) begin
            busy_m    = 1'b1;
            load_edge = n_edges;
            pend_val  = val;
        end
        @(negedge Clk);
        check_outputs();
    endtask

    task automatic idle(input int n, input bit hab);
        for (int i = 0; i < n; i++) cycle(1'b0, 0, hab);
    endtask

    task automatic model_reset();
        n_edges  = 0;
        busy_m   = 1'b0;
        com_val  = 0;
        prev_val = 0;
        listo_m  = 1'b0;
    endtask

    initial begin
        #1 Rst_n = 1'b0;
        #2 check_reset_values("reset_initial");
        @(negedge Clk);
        Rst_n = 1'b1;
        model_reset();

        idle(14, 1'b1);
        cycle(1'b1, 169, 1'b1); idle(22, 1'b1);
        cycle(1'b1, 255, 1'b1); idle(22, 1'b1);
        cycle(1'b1, 4, 1'b1);   idle(22, 1'b1);
        cycle(1'b1, 0, 1'b1);   idle(22, 1'b1);
        idle(14, 1'b0);
        idle(4, 1'b1);

        cycle(1'b1, 49, 1'b1); idle(3, 1'b1);
        cycle(1'b1, 25, 1'b1); idle(4, 1'b1);
        cycle(1'b1, 25, 1'b1); idle(20, 1'b1);

        cycle(1'b1, 99, 1'b1);
        for (int i = 0; i < 12; i++) cycle(1'b1, 137, 1'b1);
        idle(14, 1'b1);

        cycle(1'b1, 200, 1'b1); idle(4, 1'b1);
        #2 Rst_n = 1'b0;
        #1 check_reset_values("reset_midconv");
        @(posedge Clk);
        @(negedge Clk);
        check_reset_values("reset_held");
        Rst_n = 1'b1;
        model_reset();
        idle(16, 1'b1);
        cycle(1'b1, 123, 1'b1); idle(20, 1'b1);

        begin
            bit hab_r = 1'b1;
            for (int i = 0; i < 800; i++) begin
                int v;
                case ($urandom_range(0, 3))
                    0:       v = 0;
                    1:       v = 255;
                    default: v = int'($urandom_range(0, 255));
                endcase
                if ($urandom_range(0, 15) == 0) hab_r = ~hab_r;
                cycle($urandom_range(0, 7) == 0, v, hab_r);
            end
        end
        idle(20, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seg_display_driver.md
SEG_DISPLAY_DRIVER -- requirements
Module: seg_display_driver

Interface
REQ-001 Parameter DATA_W, default 8: binary input width, legal range 1..26.
REQ-002 Parameter DIGITS, default 3: number of scanned digits, legal range 1..8.
REQ-003 Parameter SCAN_DIV, default 100_000: Clk cycles per digit slot, minimum 2.
REQ-004 Parameter BLANK_LZ, default 1: when 1, blank leading zeros.
REQ-005 Clk  in  1  single system clock; all state updates on its rising edge.
REQ-006 Rst_n  in  1  reset, asynchronous and active-low.
REQ-007 Valor  in  DATA_W  unsigned binary value to display.
REQ-008 Cargar  in  1  load strobe, sampled on the Clk rising edge.
REQ-009 Habilitar  in  1  display enable; 0 blanks the panel.
REQ-010 Ocupado  out  1  conversion in progress.
REQ-011 Listo  out  1  one-cycle pulse when new digits are committed.
REQ-012 Desborde  out  1  committed value exceeds 10^DIGITS-1.
REQ-013 Displays  out  8  digit-select lines, active-low, one-hot-zero.
REQ-014 Segmentos  out  8  segment lines, active-low, bit7 = dp (always 1), bits6..0 = g..a.

Function
REQ-015 The FSM SHALL have three states: IDLE, CONV and DONE; reset state is IDLE.
REQ-016 IDLE with Cargar=1 SHALL capture Valor and enter CONV; Cargar in CONV or DONE SHALL be ignored (not queued).
REQ-017 CONV SHALL run a shift-add-3 double-dabble for exactly DATA_W cycles on DIGITS+1 BCD nibbles plus a sticky bit set by any carry out of the top nibble, then enter DONE.
REQ-018 DONE SHALL last one cycle: set Desborde = (top nibble != 0) | sticky, copy the DIGITS low nibbles into the display registers, pulse Listo, then return to IDLE.
REQ-019 Ocupado SHALL be 1 exactly in CONV and DONE; with Cargar sampled at edge k, Listo is high in cycle k+DATA_W+1 and new digits are shown from cycle k+DATA_W+2.
REQ-020 Display registers SHALL change only in DONE; the panel never shows a partial conversion.
REQ-021 The scan counter SHALL count 0..SCAN_DIV-1 and wrap; at wrap, the digit index SHALL advance 0..DIGITS-1 and wrap to 0.
REQ-022 Displays bit i SHALL be 0 only when i equals the digit index and Habilitar=1; bits DIGITS..7 SHALL stay 1.
REQ-023 Digit index 0 SHALL be the least-significant digit.
REQ-024 Segment codes: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, blank=FF, dash=BF (hex).
REQ-025 When Desborde=1, every enabled digit SHALL show dash.
REQ-026 When BLANK_LZ=1, zero digits above the most-significant nonzero digit SHALL show blank; digit 0 SHALL always show a numeral.
REQ-027 When Habilitar=0, Displays SHALL be FF and Segmentos FF, while scan counters keep running.
REQ-028 Displays and Segmentos SHALL be registered outputs (one-cycle latency from index/digit change), free of glitches.

Reset
REQ-029 Rst_n=0 SHALL immediately force: FSM to IDLE; Ocupado=0, Listo=0, Desborde=0; Displays=FF, Segmentos=FF; scan counter, digit index and all digit registers to 0.
REQ-030 Reset asserted mid-conversion SHALL abort it; after release the panel shows 0 and no Listo pulse occurs.

Structure
REQ-031 Package seg_pkg SHALL hold the FSM state typedef and the segment-code constants (digit table, blank, dash).
REQ-032 The double-dabble datapath SHALL be the sub-module bin2bcd_seq with start/busy/done handshake. Scan timing and segment encoding SHALL stay in seg_display_driver.

Verification
REQ-033 DATA_W=8, DIGITS=3: Cargar with Valor=169 -> Listo exactly 9 cycles later; digits shown 9,6,1; Desborde=0.
REQ-034 Valor=255, DIGITS=2 -> Desborde=1; both digits show BF.
REQ-035 BLANK_LZ=1, Valor=4 -> digit0=99, digits1..2=FF; Valor=0 -> digit0=C0.
REQ-036 SCAN_DIV=4 -> Displays cycles FE, FD, FB, each held 4 cycles; Habilitar=0 -> Displays=FF and Segmentos=FF.
REQ-037 Second Cargar (Valor=25) during CONV of Valor=49 -> ignored; digits show 4,9 and only one Listo pulse occurs.
REQ-038 Rst_n pulsed low mid-CONV -> outputs take their REQ-029 values asynchronously; no Listo follows; the next Cargar converts normally.
